cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
Parametrised coprocessor-0 exception and interrupt controller for the pipelined MIPS core. Generalises the single `irq` input to N_IRQ lines, with a per-line level/edge mode, masking, a pending register, EPC capture, and a 3-level interrupt-enable stack that RFE pops. It sits beside the execute stage: it samples the EXEC-stage PC/valid and drives a one-cycle `takeExc` that the hazard manager turns into flush plus redirect. It also serves MFC/MTC register accesses.

Parameters:
N_IRQ, 4, number of external interrupt lines (1..8)
ADDR_W, 32, PC/EPC width
SYNC_STAGES, 2, synchroniser flops per irq line (>=1)
EDGE_MODE, {N_IRQ{1'b0}}, per-line mode; 1 = rising-edge latched, 0 = level
VECTOR, 32'h0000_0080, exception handler address

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
irq  in  N_IRQ  external interrupt lines, asynchronous
wrongInst  in  1  reserved/illegal instruction flagged in EXEC
pcEXEC  in  ADDR_W  PC of the instruction in EXEC
validEXEC  in  1  EXEC holds a real (non-bubble) instruction
stall  in  1  pipeline stall; no take/RFE/MTC commits while high
RFE  in  1  RFE instruction in EXEC
MTC  in  1  move-to-CP0 in EXEC
MFC  in  1  move-from-CP0 read enable
regSel  in  5  CP0 register number: 12 STATUS, 13 CAUSE, 14 EPC
wdata  in  32  MTC data
rdata  out  32  MFC data, combinational; 0 when MFC low or regSel unmapped
takeExc  out  1  one-cycle exception-taken pulse (flush + redirect)
excVector  out  ADDR_W  constant VECTOR
epc  out  ADDR_W  current EPC

Behaviour:
- Clocking: one clock, `clk`. Reset `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset values: STATUS=0 (all IE bits and IM clear), CAUSE=0, EPC=0, synchronisers=0, edge-detect history=0, takeExc=0.
- STATUS layout: [0] IEc, [1] IEp, [2] IEo, [8+:N_IRQ] IM; all other bits read 0.
- CAUSE layout: [6:2] ExcCode (0=Int, 10=RI), [8+:N_IRQ] IP; all other bits read 0.
- Synchroniser: each irq line passes through SYNC_STAGES flops, giving `s`.
- Edge line: IP set on the cycle `s` goes 0->1. Cleared by MTC to CAUSE writing 1 to that IP bit. If a set and a clear land in the same cycle, set wins.
- Level line: IP = `s` directly. MTC has no effect on that bit.
- commit = validEXEC & !stall.
- intReq = |(IP & IM) & IEc & commit.
- excReq = wrongInst & commit. excReq ignores IEc, so nested exceptions are allowed.
- take = excReq | intReq. Registered: takeExc is high the cycle after take, for exactly 1 cycle.
- On take, priority excReq > intReq:
  - EPC <= pcEXEC.
  - ExcCode <= 10 if excReq, else 0.
  - IE stack pushes: {IEo,IEp,IEc} <= {IEp,IEc,0}.
- RFE & commit & !take: pops {IEo,IEp,IEc} <= {IEo,IEo,IEp}. EPC is not changed. Software jumps via JR to EPC.
- MTC & commit & !take: writes the selected register.
  - STATUS writes IE[2:0] and IM.
  - EPC writes fully.
  - CAUSE is write-1-to-clear on edge IP bits only; ExcCode is read-only.
- Same cycle, take with RFE or MTC: take wins, and the RFE/MTC is discarded, because that instruction is flushed.
- Stall: while stall=1, no state changes except the synchroniser flops and edge-IP capture.
- Latency: irq rising edge to takeExc is SYNC_STAGES+2 cycles minimum, given IM/IEc set and validEXEC high.
- Interrupt re-entry is blocked after a take because IEc=0. It resumes only after RFE restores IEc.
- Reset while takeExc is high: takeExc=0 the next cycle, and all state returns to reset values.

Test Plan:
1. Reset, then MTC STATUS=0x0000_0101 (IEc=1, IM0=1). Raise irq[0] (level) with validEXEC=1, pcEXEC=0x0000_0040 -> takeExc pulses exactly 4 cycles after the irq edge (SYNC_STAGES=2). EPC=0x40, ExcCode=0, STATUS[2:0]=3'b010.
2. Same setup, but hold stall=1 over the would-be take cycle -> no takeExc while stalled. Take occurs on the first cycle with stall=0, capturing the pcEXEC of that cycle.
3. Edge line: EDGE_MODE[1]=1, IM1=1, IEc=0. Pulse irq[1] for 1 cycle -> CAUSE IP1 reads 1 and stays 1 with no take. MTC CAUSE=0x200 -> IP1=0. Repeat the pulse and set IEc=1 -> one take.
4. wrongInst=1 with IEc=0 and pcEXEC=0x1234 -> takeExc, EPC=0x1234, ExcCode=10 (CAUSE[6:2]=5'b01010). wrongInst together with a pending enabled interrupt -> ExcCode=10.
5. Nested sequence: take (IE stack 001->010), wrongInst take (010->100), RFE (->110), RFE (->111... i.e. {IEo,IEo,IEp}). Check each stack value after every step.
6. Same-cycle conflict: RFE=1 and intReq together -> take wins, IE stack pushes rather than pops. MTC EPC=0xFFFF_0000 in the same cycle as a take -> EPC=pcEXEC.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: synchronised IRQ lines with level/edge
// pending bits, STATUS/CAUSE/EPC registers, a 3-deep IE stack and a one-cycle take pulse.
module cp0_exc_ctrl #(
   parameter int                N_IRQ       = 4,
   parameter int                ADDR_W      = 32,
   parameter int                SYNC_STAGES = 2,
   parameter logic [N_IRQ-1:0]  EDGE_MODE   = '0,
   parameter logic [ADDR_W-1:0] VECTOR      = 32'h0000_0080
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_IRQ-1:0]  irq,
   input  logic              wrongInst,
   input  logic [ADDR_W-1:0] pcEXEC,
   input  logic              validEXEC,
   input  logic              stall,
   input  logic              RFE,
   input  logic              MTC,
   input  logic              MFC,
   input  logic [4:0]        regSel,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              takeExc,
   output logic [ADDR_W-1:0] excVector,
   output logic [ADDR_W-1:0] epc
);

   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;
   localparam logic [4:0] EXC_INT    = 5'd0;
   localparam logic [4:0] EXC_RI     = 5'd10;

   logic [N_IRQ-1:0]  sync_q [SYNC_STAGES];
   logic [N_IRQ-1:0]  sync_d [SYNC_STAGES];
   logic [N_IRQ-1:0]  hist_q, hist_d;
   logic [N_IRQ-1:0]  ip_q, ip_d;
   logic [N_IRQ-1:0]  im_q, im_d;
   logic [2:0]        ie_q, ie_d;
   logic [4:0]        exc_q, exc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic              take_q, take_d;

   logic [N_IRQ-1:0]  s;
   logic [N_IRQ-1:0]  rise;
   logic [N_IRQ-1:0]  ip_clr;
   logic              commit;
   logic              int_req;
   logic              exc_req;
   logic              take;
   logic [31:0]       status_w;
   logic [31:0]       cause_w;

   assign s       = sync_q[SYNC_STAGES-1];
   assign rise    = s & ~hist_q;
   assign commit  = validEXEC & ~stall;
   assign int_req = (|(ip_q & im_q)) & ie_q[0] & commit;
   assign exc_req = wrongInst & commit;
   assign take    = exc_req | int_req;

   always_comb begin
      sync_d[0] = irq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      hist_d = s;
   end

   // Level lines mirror the synchroniser (one more register stage); edge lines latch until cleared.
   always_comb begin
      for (int i = 0; i < N_IRQ; i++) begin
         if (EDGE_MODE[i]) begin
            ip_d[i] = rise[i] | (ip_q[i] & ~ip_clr[i]);
         end else begin
            ip_d[i] = s[i];
         end
      end
   end

   always_comb begin
      ie_d   = ie_q;
      im_d   = im_q;
      exc_d  = exc_q;
      epc_d  = epc_q;
      ip_clr = '0;
      take_d = take;
      if (take) begin
         epc_d = pcEXEC;
         exc_d = exc_req ? EXC_RI : EXC_INT;
         ie_d  = {ie_q[1:0], 1'b0};
      end else if (commit && RFE) begin
         ie_d = {ie_q[2], ie_q[2], ie_q[1]};
      end else if (commit && MTC) begin
         case (regSel)
            REG_STATUS: begin
               ie_d = wdata[2:0];
               im_d = wdata[8 +: N_IRQ];
            end
            REG_CAUSE: ip_clr = wdata[8 +: N_IRQ] & EDGE_MODE;
            REG_EPC:   epc_d  = ADDR_W'(wdata);
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         hist_q <= '0;
         ip_q   <= '0;
         im_q   <= '0;
         ie_q   <= '0;
         exc_q  <= '0;
         epc_q  <= '0;
         take_q <= 1'b0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         hist_q <= hist_d;
         ip_q   <= ip_d;
         im_q   <= im_d;
         ie_q   <= ie_d;
         exc_q  <= exc_d;
         epc_q  <= epc_d;
         take_q <= take_d;
      end
   end

   always_comb begin
      status_w               = '0;
      status_w[2:0]          = ie_q;
      status_w[8 +: N_IRQ]   = im_q;
      cause_w                = '0;
      cause_w[6:2]           = exc_q;
      cause_w[8 +: N_IRQ]    = ip_q;
      rdata                  = '0;
      if (MFC) begin
         case (regSel)
            REG_STATUS: rdata = status_w;
            REG_CAUSE:  rdata = cause_w;
            REG_EPC:    rdata = 32'(epc_q);
            default:    rdata = '0;
         endcase
      end
   end

   assign takeExc   = take_q;
   assign excVector = VECTOR;
   assign epc       = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed-vector bench for cp0_exc_ctrl: IRQ latency, stall, edge lines, RI, nesting, conflicts.
module tb_cp0_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  irq;
   logic        wrongInst;
   logic [31:0] pcEXEC;
   logic        validEXEC;
   logic        stall;
   logic        RFE;
   logic        MTC;
   logic        MFC;
   logic [4:0]  regSel;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        takeExc;
   logic [31:0] excVector;
   logic [31:0] epc;

   int n_vec  = 0;
   int n_miss = 0;

   cp0_exc_ctrl #(
      .N_IRQ(4), .ADDR_W(32), .SYNC_STAGES(2),
      .EDGE_MODE(4'b0010), .VECTOR(32'h0000_0080)
   ) dut (
      .clk(clk), .rst(rst), .irq(irq), .wrongInst(wrongInst),
      .pcEXEC(pcEXEC), .validEXEC(validEXEC), .stall(stall),
      .RFE(RFE), .MTC(MTC), .MFC(MFC), .regSel(regSel), .wdata(wdata),
      .rdata(rdata), .takeExc(takeExc), .excVector(excVector), .epc(epc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_reg(input string tag, input logic [4:0] sel, input logic [31:0] exp);
      logic [31:0] v;
      MFC = 1'b1;
      regSel = sel;
      #1;
      v = rdata;
      MFC = 1'b0;
      check(tag, v, exp);
   endtask

   task automatic mtc(input logic [4:0] sel, input logic [31:0] data);
      validEXEC = 1'b1;
      MTC = 1'b1;
      regSel = sel;
      wdata = data;
      tick();
      MTC = 1'b0;
      validEXEC = 1'b0;
   endtask

   task automatic rfe();
      validEXEC = 1'b1;
      RFE = 1'b1;
      tick();
      RFE = 1'b0;
      validEXEC = 1'b0;
   endtask

   initial begin
      rst = 1'b1; irq = '0; wrongInst = 1'b0; pcEXEC = '0; validEXEC = 1'b0;
      stall = 1'b0; RFE = 1'b0; MTC = 1'b0; MFC = 1'b0; regSel = '0; wdata = '0;
      idle(2);
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_take", {31'd0, takeExc}, 32'd0);
      check_reg("rst_status", 5'd12, 32'h0);
      check_reg("rst_cause", 5'd13, 32'h0);
      check("rst_epc", epc, 32'h0);
      check("vector", excVector, 32'h80);

      // 1: level IRQ latency = SYNC_STAGES+2
      mtc(5'd12, 32'h0000_0101);
      validEXEC = 1'b1; pcEXEC = 32'h40; irq[0] = 1'b1;
      idle(3);
      check("t1_take_early", {31'd0, takeExc}, 32'd0);
      tick();
      check("t1_take", {31'd0, takeExc}, 32'd1);
      tick();
      check("t1_take_once", {31'd0, takeExc}, 32'd0);
      check("t1_epc", epc, 32'h40);
      check_reg("t1_cause", 5'd13, 32'h100);
      check_reg("t1_status", 5'd12, 32'h102);

      // 2: stall holds off the take
      validEXEC = 1'b0; irq[0] = 1'b0;
      idle(4);
      mtc(5'd12, 32'h0000_0101);
      validEXEC = 1'b1; stall = 1'b1; pcEXEC = 32'h50; irq[0] = 1'b1;
      idle(4);
      check("t2_stall_a", {31'd0, takeExc}, 32'd0);
      tick();
      check("t2_stall_b", {31'd0, takeExc}, 32'd0);
      stall = 1'b0; pcEXEC = 32'h60;
      tick();
      check("t2_take", {31'd0, takeExc}, 32'd1);
      check("t2_epc", epc, 32'h60);
      validEXEC = 1'b0; irq[0] = 1'b0;
      idle(4);

      // 3: edge line 1
      mtc(5'd12, 32'h0000_0200);
      validEXEC = 1'b1; irq[1] = 1'b1;
      tick();
      irq[1] = 1'b0;
      idle(4);
      check("t3_no_take", {31'd0, takeExc}, 32'd0);
      check_reg("t3_ip_set", 5'd13, 32'h200);
      validEXEC = 1'b0;
      mtc(5'd13, 32'h0000_0200);
      check_reg("t3_ip_clr", 5'd13, 32'h0);
      irq[1] = 1'b1;
      tick();
      irq[1] = 1'b0;
      idle(4);
      check_reg("t3_ip_again", 5'd13, 32'h200);
      mtc(5'd12, 32'h0000_0201);
      validEXEC = 1'b1; pcEXEC = 32'h70;
      tick();
      check("t3_take", {31'd0, takeExc}, 32'd1);
      tick();
      check("t3_take_once", {31'd0, takeExc}, 32'd0);
      check("t3_epc", epc, 32'h70);
      validEXEC = 1'b0;
      mtc(5'd13, 32'h0000_0200);

      // 4: reserved instruction, with IEc=0 and then with a pending interrupt
      validEXEC = 1'b1; wrongInst = 1'b1; pcEXEC = 32'h1234;
      tick();
      wrongInst = 1'b0; validEXEC = 1'b0;
      check("t4_take", {31'd0, takeExc}, 32'd1);
      check("t4_epc", epc, 32'h1234);
      check_reg("t4_cause", 5'd13, 32'h28);
      check_reg("t4_status", 5'd12, 32'h204);
      mtc(5'd12, 32'h0000_0101);
      irq[0] = 1'b1;
      idle(4);
      validEXEC = 1'b1; wrongInst = 1'b1; pcEXEC = 32'h88;
      tick();
      wrongInst = 1'b0; validEXEC = 1'b0;
      check("t4b_take", {31'd0, takeExc}, 32'd1);
      check_reg("t4b_cause", 5'd13, 32'h128);
      check("t4b_epc", epc, 32'h88);

      // 5: nested take / RI / RFE / RFE
      mtc(5'd12, 32'h0000_0101);
      validEXEC = 1'b1; pcEXEC = 32'h100;
      tick();
      validEXEC = 1'b0;
      check("t5_take", {31'd0, takeExc}, 32'd1);
      check_reg("t5_st1", 5'd12, 32'h102);
      check_reg("t5_cause", 5'd13, 32'h100);
      validEXEC = 1'b1; wrongInst = 1'b1; pcEXEC = 32'h104;
      tick();
      wrongInst = 1'b0; validEXEC = 1'b0;
      check_reg("t5_st2", 5'd12, 32'h104);
      rfe();
      check_reg("t5_st3", 5'd12, 32'h106);
      rfe();
      check_reg("t5_st4", 5'd12, 32'h107);

      // 6: take beats RFE and MTC in the same cycle
      validEXEC = 1'b1; RFE = 1'b1; pcEXEC = 32'h200;
      tick();
      RFE = 1'b0; validEXEC = 1'b0;
      check("t6_take_rfe", {31'd0, takeExc}, 32'd1);
      check_reg("t6_status", 5'd12, 32'h106);
      check("t6_epc", epc, 32'h200);
      mtc(5'd12, 32'h0000_0101);
      validEXEC = 1'b1; MTC = 1'b1; regSel = 5'd14; wdata = 32'hFFFF_0000; pcEXEC = 32'h300;
      tick();
      MTC = 1'b0; validEXEC = 1'b0;
      check("t6_take_mtc", {31'd0, takeExc}, 32'd1);
      check("t6_epc_mtc", epc, 32'h300);
      mtc(5'd14, 32'hFFFF_0000);
      check("t6_epc_wr", epc, 32'hFFFF_0000);
      check_reg("rd_unmapped", 5'd5, 32'h0);
      MFC = 1'b0; regSel = 5'd14;
      #1;
      check("rd_mfc_low", rdata, 32'h0);

      // Reset while takeExc is high
      irq = '0;
      validEXEC = 1'b1; wrongInst = 1'b1; pcEXEC = 32'h400;
      tick();
      wrongInst = 1'b0; validEXEC = 1'b0;
      check("rst_pre_take", {31'd0, takeExc}, 32'd1);
      rst = 1'b1;
      tick();
      check("rst2_take", {31'd0, takeExc}, 32'd0);
      check("rst2_epc", epc, 32'h0);
      check_reg("rst2_status", 5'd12, 32'h0);
      check_reg("rst2_cause", 5'd13, 32'h0);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
